// File: rtl/pong_score_keeper_pkg.sv
// Shared types and constants for the Pong score keeper.
package pong_pkg;

  // Width of each player's score; 3 bits drive the digit decoders directly.
  localparam int SCORE_W = 3;

  // Player indices, also used as the encoding of the winner flag.
  localparam int P1 = 0;
  localparam int P2 = 1;

  // Game sequencing states.
  typedef enum logic [1:0] {
    PLAY,
    SERVE_WAIT,
    GAME_OVER
  } state_t;

endpackage

// File: rtl/pong_score_keeper_if.sv
// Bundle between the game logic (master) and the score keeper (slave).
interface pong_score_keeper_if;
  import pong_pkg::*;

  logic               point_p1;
  logic               point_p2;
  logic               new_game;
  logic [SCORE_W-1:0] score_p1;
  logic [SCORE_W-1:0] score_p2;
  logic               serve_en;
  logic               game_over;
  logic               winner;
  logic               blank_p1;
  logic               blank_p2;

  modport master (
    output point_p1, point_p2, new_game,
    input  score_p1, score_p2, serve_en, game_over, winner, blank_p1, blank_p2
  );

  modport slave (
    input  point_p1, point_p2, new_game,
    output score_p1, score_p2, serve_en, game_over, winner, blank_p1, blank_p2
  );

endinterface

// File: rtl/pong_score_keeper_rise_detect.sv
// Rising-edge detector: one-cycle pulse when d is high now and was low
// on the previous clock edge. A held level therefore produces one pulse.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic r_prev;

  // Remember last cycle's level of d.
  always_ff @(posedge clk) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= d;
  end

  assign pulse = d & ~r_prev;

endmodule

// File: rtl/pong_score_keeper.sv
// Pong score keeper: counts points per player, paces serves with a pause
// after every point, detects the winner and blinks the winner's digit.
module pong_score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = 7,
  parameter int SERVE_DELAY = 50_000_000,
  parameter int BLINK_HALF  = 12_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  pong_score_keeper_if.slave bus
);

  localparam int SW = $clog2(SERVE_DELAY + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  // After a point/restart the counter expires at zero, so loading DELAY-1
  // gives serve_en exactly DELAY edges later. Out of reset it is loaded with
  // DELAY so the pause is counted from the first edge with rst_n high.
  localparam logic [SW-1:0]      SERVE_LOAD = SW'(SERVE_DELAY - 1);
  localparam logic [SW-1:0]      SERVE_RST  = SW'(SERVE_DELAY);
  localparam logic [BW-1:0]      BLINK_LAST = BW'(BLINK_HALF - 1);

  state_t             r_state;
  state_t             w_nextState;
  logic [SCORE_W-1:0] r_scoreP1;
  logic [SCORE_W-1:0] r_scoreP2;
  logic [SW-1:0]      r_serveCnt;
  logic [BW-1:0]      r_blinkCnt;
  logic               r_blinkPhase;
  logic               r_winner;
  logic               r_blankP1;
  logic               r_blankP2;
  logic               r_serveEn;
  logic               r_gameOver;

  logic w_riseP1;
  logic w_riseP2;
  logic w_soloP1;
  logic w_soloP2;
  logic w_winP1;
  logic w_winP2;

  rise_detect u_riseP1 (.clk(clk), .rst_n(rst_n), .d(bus.point_p1), .pulse(w_riseP1));
  rise_detect u_riseP2 (.clk(clk), .rst_n(rst_n), .d(bus.point_p2), .pulse(w_riseP2));

  // Simultaneous edges cancel out (replayed serve), so only a lone edge scores.
  assign w_soloP1 = w_riseP1 & ~w_riseP2;
  assign w_soloP2 = w_riseP2 & ~w_riseP1;
  assign w_winP1  = w_soloP1 && ((r_scoreP1 + SCORE_W'(1)) == WIN_VAL);
  assign w_winP2  = w_soloP2 && ((r_scoreP2 + SCORE_W'(1)) == WIN_VAL);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= SERVE_WAIT;
    else        r_state <= w_nextState;
  end

  // Next-state logic; a restart request beats everything else.
  always_comb begin
    w_nextState = r_state;
    if (bus.new_game) begin
      w_nextState = SERVE_WAIT;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_winP1 || w_winP2)        w_nextState = GAME_OVER;
          else if (w_riseP1 || w_riseP2) w_nextState = SERVE_WAIT;
        end
        SERVE_WAIT: begin
          if (r_serveCnt == '0) w_nextState = PLAY;
        end
        GAME_OVER: w_nextState = GAME_OVER;
        default:   w_nextState = SERVE_WAIT;
      endcase
    end
  end

  // Scores, serve pause counter, winner latch and blink generator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_scoreP1    <= '0;
      r_scoreP2    <= '0;
      r_serveCnt   <= SERVE_RST;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
      r_winner     <= 1'b0;
      r_blankP1    <= 1'b0;
      r_blankP2    <= 1'b0;
    end else if (bus.new_game) begin
      r_scoreP1    <= '0;
      r_scoreP2    <= '0;
      r_serveCnt   <= SERVE_LOAD;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
      r_winner     <= 1'b0;
      r_blankP1    <= 1'b0;
      r_blankP2    <= 1'b0;
    end else begin
      case (r_state)
        PLAY: begin
          if (w_soloP1) r_scoreP1 <= r_scoreP1 + SCORE_W'(1);
          if (w_soloP2) r_scoreP2 <= r_scoreP2 + SCORE_W'(1);
          if (w_riseP1 || w_riseP2) r_serveCnt <= SERVE_LOAD;
          if (w_winP1) r_winner <= 1'(P1);
          if (w_winP2) r_winner <= 1'(P2);
          r_blinkCnt   <= '0;
          r_blinkPhase <= 1'b0;
        end
        SERVE_WAIT: begin
          if (r_serveCnt != '0) r_serveCnt <= r_serveCnt - SW'(1);
        end
        GAME_OVER: begin
          if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
            r_blankP1    <= (r_winner == 1'(P1)) & ~r_blinkPhase;
            r_blankP2    <= (r_winner == 1'(P2)) & ~r_blinkPhase;
          end else begin
            r_blinkCnt <= r_blinkCnt + BW'(1);
          end
        end
        default: r_serveCnt <= SERVE_LOAD;
      endcase
    end
  end

  // Registered status flags decoded from the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_serveEn  <= 1'b0;
      r_gameOver <= 1'b0;
    end else begin
      r_serveEn  <= (w_nextState == PLAY);
      r_gameOver <= (w_nextState == GAME_OVER);
    end
  end

  assign bus.score_p1  = r_scoreP1;
  assign bus.score_p2  = r_scoreP2;
  assign bus.serve_en  = r_serveEn;
  assign bus.game_over = r_gameOver;
  assign bus.winner    = r_winner;
  assign bus.blank_p1  = r_blankP1;
  assign bus.blank_p2  = r_blankP2;

endmodule

// File: tb/tb_pong_score_keeper.sv
// Testbench for pong_score_keeper with WIN_SCORE=3, SERVE_DELAY=4, BLINK_HALF=3.
// Table rows hold the inputs applied before a clock edge and the outputs
// expected after it; expectations are queued on drive and popped on sample.
module tb_pong_score_keeper;
  import pong_pkg::*;

  localparam int WIN = 3;
  localparam int SD  = 4;
  localparam int BH  = 3;

  typedef struct {
    logic        rstN;
    logic        p1;
    logic        p2;
    logic        ng;
    logic [10:0] exp;   // {score_p1, score_p2, serve_en, game_over, winner, blank_p1, blank_p2}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  vec_t        tbl[$];
  logic [10:0] expQ[$];
  logic [10:0] obs;

  pong_score_keeper_if bus();

  pong_score_keeper #(
    .WIN_SCORE(WIN),
    .SERVE_DELAY(SD),
    .BLINK_HALF(BH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  assign obs = {bus.score_p1, bus.score_p2, bus.serve_en, bus.game_over,
                bus.winner, bus.blank_p1, bus.blank_p2};

  function automatic vec_t mv(input int r, input int a, input int b, input int n,
                              input int s1, input int s2, input int se, input int go,
                              input int w, input int b1, input int b2);
    vec_t v;
    v.rstN = 1'(r);
    v.p1   = 1'(a);
    v.p2   = 1'(b);
    v.ng   = 1'(n);
    v.exp  = {3'(s1), 3'(s2), 1'(se), 1'(go), 1'(w), 1'(b1), 1'(b2)};
    return v;
  endfunction

  function automatic void add(input int n, input vec_t v);
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endfunction

  task automatic driveIn(input logic r, input logic a, input logic b, input logic n);
    rst_n        = r;
    bus.point_p1 = a;
    bus.point_p2 = b;
    bus.new_game = n;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input vec_t v);
    driveIn(v.rstN, v.p1, v.p2, v.ng);
    expQ.push_back(v.exp);
  endtask

  task automatic checkOutput(input int idx);
    logic [10:0] e;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL vec%0d: no expectation queued", idx);
    end else begin
      e = expQ.pop_front();
      checks++;
      if (obs !== e)begin
        errors++;
        $display("[TB] FAIL vec%0d: got s1=%0d s2=%0d se=%b go=%b w=%b b1=%b b2=%b, want s1=%0d s2=%0d se=%b go=%b w=%b b1=%b b2=%b",
                 idx, obs[10:8], obs[7:5], obs[4], obs[3], obs[2], obs[1], obs[0],
                 e[10:8], e[7:5], e[4], e[3], e[2], e[1], e[0]);
      end
    end
  endtask

  task automatic checkVal(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Hard stop in case the stimulus never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence.
  initial begin
    int n;
    driveIn(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held two edges, then the serve pause counted from the first released edge.
    add(2, mv(0,0,0,0, 0,0,0,0,0,0,0));
    add(4, mv(1,0,0,0, 0,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 0,0,1,0,0,0,0));
    // point_p1 held for 10 cycles counts once.
    add(4, mv(1,1,0,0, 1,0,0,0,0,0,0));
    add(6, mv(1,1,0,0, 1,0,1,0,0,0,0));
    add(1, mv(1,0,0,0, 1,0,1,0,0,0,0));
    // Simultaneous edges: replayed serve, no score change.
    add(1, mv(1,1,1,0, 1,0,0,0,0,0,0));
    add(3, mv(1,0,0,0, 1,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 1,0,1,0,0,0,0));
    // Restart from PLAY clears player 1.
    add(1, mv(1,0,0,1, 0,0,0,0,0,0,0));
    add(3, mv(1,0,0,0, 0,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 0,0,1,0,0,0,0));
    // Player 2 scores three times and wins.
    add(1, mv(1,0,1,0, 0,1,0,0,0,0,0));
    add(3, mv(1,0,0,0, 0,1,0,0,0,0,0));
    add(1, mv(1,0,0,0, 0,1,1,0,0,0,0));
    add(1, mv(1,0,1,0, 0,2,0,0,0,0,0));
    add(3, mv(1,0,0,0, 0,2,0,0,0,0,0));
    add(1, mv(1,0,0,0, 0,2,1,0,0,0,0));
    add(1, mv(1,0,1,0, 0,3,0,1,1,0,0));
    // Blink 0,0,0,1,1,1,0,0,0,1 on player 2; point edges ignored.
    add(1, mv(1,0,0,0, 0,3,0,1,1,0,0));
    add(1, mv(1,1,0,0, 0,3,0,1,1,0,0));
    add(1, mv(1,0,1,0, 0,3,0,1,1,0,1));
    add(1, mv(1,0,0,0, 0,3,0,1,1,0,1));
    add(1, mv(1,1,0,0, 0,3,0,1,1,0,1));
    add(3, mv(1,0,0,0, 0,3,0,1,1,0,0));
    add(1, mv(1,0,0,0, 0,3,0,1,1,0,1));
    // new_game with a simultaneous point_p1 rise while the digit is blanked.
    add(1, mv(1,1,0,1, 0,0,0,0,0,0,0));
    add(3, mv(1,0,0,0, 0,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 0,0,1,0,0,0,0));
    // Reset mid-SERVE_WAIT.
    add(1, mv(1,1,0,0, 1,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 1,0,0,0,0,0,0));
    add(1, mv(0,0,0,0, 0,0,0,0,0,0,0));
    add(4, mv(1,0,0,0, 0,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 0,0,1,0,0,0,0));
    // Player 1 wins, then reset mid-GAME_OVER while blanked.
    add(1, mv(1,1,0,0, 1,0,0,0,0,0,0));
    add(3, mv(1,0,0,0, 1,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 1,0,1,0,0,0,0));
    add(1, mv(1,1,0,0, 2,0,0,0,0,0,0));
    add(3, mv(1,0,0,0, 2,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 2,0,1,0,0,0,0));
    add(1, mv(1,1,0,0, 3,0,0,1,0,0,0));
    add(2, mv(1,0,0,0, 3,0,0,1,0,0,0));
    add(1, mv(1,0,0,0, 3,0,0,1,0,1,0));
    add(1, mv(0,0,0,0, 0,0,0,0,0,0,0));
    add(4, mv(1,0,0,0, 0,0,0,0,0,0,0));
    add(1, mv(1,0,0,0, 0,0,1,0,0,0,0));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkOutput(i);
    end

    // Serve pause measured with a bounded wait after a player 2 point.
    driveIn(1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    checkVal("p2 point score", int'(bus.score_p2), 1);
    checkVal("p2 point serve_en", int'(bus.serve_en), 0);
    driveIn(1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (bus.serve_en !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checkVal("serve pause length", n, SD);

    // Restart overrides simultaneous point edges in PLAY.
    driveIn(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    checkVal("override score_p1", int'(bus.score_p1), 0);
    checkVal("override score_p2", int'(bus.score_p2), 0);
    checkVal("override serve_en", int'(bus.serve_en), 0);
    driveIn(1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
